// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared MD op encodings and default latencies for decoder, hazard unit and MD unit
package mult_div_unit_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  function automatic logic is_md_op(logic [2:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: command operands in, busy/stall and HI/LO out
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, src_a, src_b, input busy, md_stall, hi, lo);
  modport slave (input start, md_op, src_a, src_b, output busy, md_stall, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency multiply/divide unit owning the architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  mult_div_unit_if.slave md
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic [2:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, dvs, quo, rem, res_hi, res_lo;
  logic sgn, is_div, done, wr, idle_cmd, launch;
  always_comb begin
    sgn = op_q == MD_DIV;
    is_div = op_q == MD_DIV || op_q == MD_DIVU;
    // sign-extended operands make the low 64 bits of the product the signed result
    prod = op_q == MD_MULT ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q} : {32'd0, a_q} * {32'd0, b_q};
    mag_a = sgn && a_q[31] ? -a_q : a_q;
    mag_b = sgn && b_q[31] ? -b_q : b_q;
    dvs = mag_b == '0 ? 32'd1 : mag_b;
    quo = mag_a / dvs;
    rem = mag_a % dvs;
    res_lo = is_div ? (sgn && (a_q[31] ^ b_q[31]) ? -quo : quo) : prod[31:0];
    res_hi = is_div ? (sgn && a_q[31] ? -rem : rem) : prod[63:32];
    done = busy_q && cnt_q == CW'(1);
    wr = done && !(is_div && b_q == '0);
    idle_cmd = !busy_q && md.start;
    launch = idle_cmd && is_md_op(md.md_op);
    cnt_d = launch ? ((md.md_op == MD_DIV || md.md_op == MD_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES))
                   : busy_q ? cnt_q - 1'b1 : cnt_q;
    busy_d = launch || (busy_q && !done);
    op_d = launch ? md.md_op : op_q;
    a_d = launch ? md.src_a : a_q;
    b_d = launch ? md.src_b : b_q;
    hi_d = wr ? res_hi : (idle_cmd && md.md_op == MD_MTHI) ? md.src_a : hi_q;
    lo_d = wr ? res_lo : (idle_cmd && md.md_op == MD_MTLO) ? md.src_a : lo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      busy_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign md.busy = busy_q;
  assign md.md_stall = busy_q || (md.start && is_md_op(md.md_op));
  assign md.hi = hi_q;
  assign md.lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random MD operations checked against an arithmetic HI/LO model
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  mult_div_unit_if m ();
  mult_div_unit dut (.clk(clk), .reset(reset), .md(m));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m.start = 1'b0;
    m.md_op = 3'($urandom);
    m.src_a = $urandom;
    m.src_b = $urandom;
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p = {exp_hi, exp_lo};
    if (op == MD_MULT) p = 64'(sa * sb);
    else if (op == MD_MULTU) p = {32'd0, a} * {32'd0, b};
    else if (op == MD_DIV && b != 0) p = {32'(sa % sb), 32'(sa / sb)};
    else if (op == MD_DIVU && b != 0) p = {a % b, a / b};
    {exp_hi, exp_lo} = p;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    int n = (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
    logic [31:0] h0 = exp_hi;
    logic [31:0] l0 = exp_lo;
    m.start = 1'b1;
    m.md_op = op;
    m.src_a = a;
    m.src_b = b;
    #1 chk_b("stall_on_start", m.md_stall, 1'b1);
    tick();
    for (int k = 0; k < n; k++) begin
      if (noise && k == 2) begin
        m.start = 1'b1; m.md_op = MD_DIV; m.src_a = 32'd9; m.src_b = 32'd3;
      end else if (noise && k == 3) begin
        m.start = 1'b1; m.md_op = MD_MTLO; m.src_a = 32'h1234;
      end else idle_inputs();
      #1;
      chk_b("busy_inflight", m.busy, 1'b1);
      chk_b("stall_inflight", m.md_stall, 1'b1);
      chk("hi_hold", m.hi, h0);
      chk("lo_hold", m.lo, l0);
      tick();
    end
    idle_inputs();
    model(op, a, b);
    chk_b("busy_done", m.busy, 1'b0);
    chk("hi_result", m.hi, exp_hi);
    chk("lo_result", m.lo, exp_lo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] val);
    m.start = 1'b1;
    m.md_op = op;
    m.src_a = val;
    m.src_b = $urandom;
    #1 chk_b("stall_mt", m.md_stall, 1'b0);
    tick();
    idle_inputs();
    if (op == MD_MTHI) exp_hi = val;
    if (op == MD_MTLO) exp_lo = val;
    chk_b("busy_mt", m.busy, 1'b0);
    chk("hi_mt", m.hi, exp_hi);
    chk("lo_mt", m.lo, exp_lo);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    idle_inputs();
    tick();
    tick();
    chk_b("rst_busy", m.busy, 1'b0);
    chk_b("rst_stall", m.md_stall, 1'b0);
    chk("rst_hi", m.hi, 32'd0);
    chk("rst_lo", m.lo, 32'd0);
    reset = 1'b0;
    run_md(MD_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult_hi_const", m.hi, 32'hFFFFFFFF);
    chk("mult_lo_const", m.lo, 32'hFFFFFFF1);
    run_md(MD_DIVU, 32'd100, 32'd7, 1'b0);
    chk("divu_lo_const", m.lo, 32'd14);
    chk("divu_hi_const", m.hi, 32'd2);
    run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo_const", m.lo, 32'hFFFFFFFD);
    chk("div_hi_const", m.hi, 32'hFFFFFFFF);
    run_md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("multu_hi_const", m.hi, 32'hFFFFFFFE);
    chk("multu_lo_const", m.lo, 32'h00000001);
    mt(MD_MTHI, 32'hDEADBEEF);
    chk("mthi_const", m.hi, 32'hDEADBEEF);
    mt(MD_MTLO, 32'hCAFEF00D);
    chk("mtlo_const", m.lo, 32'hCAFEF00D);
    mt(MD_NONE, 32'h5555);
    mt(3'd7, 32'h6666);
    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    run_md(MD_DIV, 32'd5, 32'd0, 1'b0);
    chk("div0_hi_const", m.hi, 32'h11);
    chk("div0_lo_const", m.lo, 32'h22);
    run_md(MD_DIVU, 32'h1234, 32'd0, 1'b0);
    run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_ovf_lo_const", m.lo, 32'h80000000);
    chk("div_ovf_hi_const", m.hi, 32'd0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        op = 3'(32'(MD_MULT) + $urandom_range(0, 3));
        a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
        b = $urandom_range(0, 6) == 0 ? 32'd0 : ($urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 9)) : $urandom);
        run_md(op, a, b, 1'($urandom_range(0, 1)));
      end else mt($urandom_range(0, 1) != 0 ? MD_MTHI : MD_MTLO, $urandom);
    end
    mt(MD_MTHI, 32'hAAAA);
    mt(MD_MTLO, 32'h5555);
    m.start = 1'b1; m.md_op = MD_DIVU; m.src_a = 32'd1000; m.src_b = 32'd3;
    tick();
    idle_inputs();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    exp_hi = '0;
    exp_lo = '0;
    chk_b("midrst_busy", m.busy, 1'b0);
    chk("midrst_hi", m.hi, 32'd0);
    chk("midrst_lo", m.lo, 32'd0);
    reset = 1'b0;
    repeat (10) tick();
    chk_b("postrst_busy", m.busy, 1'b0);
    chk("postrst_hi", m.hi, 32'd0);
    chk("postrst_lo", m.lo, 32'd0);
    run_md(MD_MULT, 32'd7, 32'd6, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit of the five-stage MIPS pipeline; owns the architectural HI/LO registers.
- Its HI/LO outputs feed the E-to-M pipeline register's HI/LO inputs, alongside the writeHI/writeLO flags.
- Models fixed multi-cycle latency with a busy counter.
- The hazard unit stalls MD-class instructions in D while `md_stall` is high.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO update for MULT/MULTU.
- DIV_CYCLES, 10, cycles from start to HI/LO update for DIV/DIVU.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch the operation selected by md_op this cycle.
- md_op  input  3  operation select: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- src_a  input  32  rs operand, already forwarded.
- src_b  input  32  rt operand, already forwarded.
- busy  output  1  registered; high while an operation is in flight.
- md_stall  output  1  combinational: busy | (start & (md_op in MULT..DIVU)).
- hi  output  32  registered HI.
- lo  output  32  registered LO.

Behaviour:
- Reset (synchronous, wins over everything):
  - next edge: hi=0, lo=0, busy=0, counter=0, operand latches cleared.
  - An in-flight operation is abandoned with no HI/LO write.
- Idle (busy=0), start=1, md_op in {MULT,MULTU,DIV,DIVU} at edge T0:
  - Latch src_a, src_b and the op.
  - Load counter = MULT_CYCLES or DIV_CYCLES; busy=1 from T0.
- Counting:
  - Each edge with busy=1 decrements the counter.
  - At the edge where counter goes 1→0, write hi/lo from the latched operands and clear busy in the same edge.
  - Net effect: busy is high for exactly N cycles; new hi/lo is visible in cycle T0+N.
- start=1 with an MD op while busy=1: ignored. No relaunch; operand latches unchanged.
- MTHI/MTLO (start=1, md_op=5/6):
  - busy=0: hi←src_a (or lo←src_a) at that edge; busy stays 0.
  - busy=1: ignored.
- start=1 with md_op=NONE or md_op=7: no effect.
- start=0: md_op is don't-care.
- Arithmetic:
  - MULT: 64-bit signed product; hi=[63:32], lo=[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder, taking the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (src_b latched as 0, DIV or DIVU):
  - Still occupies DIV_CYCLES with busy high.
  - hi/lo left unchanged at completion.
- Result computation:
  - May be computed combinationally from the latches at completion, or precomputed at start.
  - Only the registered hi/lo timing above is observable.
- Counter width: enough bits for max(MULT_CYCLES, DIV_CYCLES); 4 bits at the defaults.
- hi/lo change only at completion, on MTHI/MTLO, or on reset.

Decomposition:
- Shared package holds:
  - md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - Default latency constants.
  - This lets the decoder and hazard unit use the same values.
- No sub-module: counter, operand latches and result mux all live in one block.

Test Plan:
- Signed multiply:
  - Stimulus: reset, then MULT with a=0xFFFFFFFD (−3), b=5 at T0.
  - Required: busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; md_stall=1 in the T0 cycle.
- Unsigned and signed divide:
  - DIVU a=100, b=7 → after 10 cycles lo=14, hi=2.
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Overlapping commands:
  - Stimulus: MULTU 0xFFFFFFFF×0xFFFFFFFF; at T0+2 issue DIV 9/3 and MTLO 0x1234.
  - Required: both ignored; final hi=0xFFFFFFFE, lo=0x00000001; busy low after exactly 5 cycles.
- Idle MTHI/MTLO:
  - MTHI 0xDEADBEEF → hi updates next edge, busy stays 0.
  - MTLO 0xCAFEF00D → lo updates.
- Divide by zero:
  - Stimulus: preload hi=0x11, lo=0x22, then DIV a=5, b=0.
  - Required: busy 10 cycles; hi=0x11, lo=0x22 after completion.
- Reset mid-operation:
  - Stimulus: DIVU launched, reset asserted at T0+4.
  - Required: next edge busy=0, hi=0, lo=0; no write at T0+10.
